// File: rtl/n64_pkg.sv
// n64_pkg
// Shared definitions for the N64/GC one-wire link (receiver and transmitter).
//   - Timing constants in sys_clk cycles for a 50 MHz clock (ONE_US = 50).
//   - Default receiver thresholds derived from those constants.
//   - Receiver state enum and stop-type encodings.
//   - Saturating byte-counter increment helper.
package n64_pkg;

    localparam int unsigned ONE_US   = 50;
    localparam int unsigned TWO_US   = 2 * ONE_US;
    localparam int unsigned THREE_US = 3 * ONE_US;
    localparam int unsigned FOUR_US  = 4 * ONE_US;

    // Receiver defaults. BIT_SPLIT sits midway between the 1 us and 3 us lows;
    // STOP_SPLIT sits midway between the 1 us and 2 us stop lows.
    localparam int unsigned GLITCH_MIN_DEF   = 10;
    localparam int unsigned BIT_SPLIT_DEF    = TWO_US;
    localparam int unsigned STOP_SPLIT_DEF   = (ONE_US + TWO_US) / 2;
    localparam int unsigned MAX_LOW_DEF      = FOUR_US + ONE_US;
    localparam int unsigned IDLE_TIMEOUT_DEF = FOUR_US + ONE_US;
    localparam int unsigned CNT_W_DEF        = 9;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_LOW   = 2'd1,
        RX_HIGH  = 2'd2,
        RX_DRAIN = 2'd3
    } rx_state_e;

    localparam logic STOP_CONSOLE    = 1'b0;
    localparam logic STOP_CONTROLLER = 1'b1;

    function automatic logic [5:0] byte_cnt_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/n64_line_sync.sv
// n64_line_sync
// Two-flop synchronizer for the asynchronous data line plus edge pulses on
// the synchronized value. Flops preset to 1 so the idle (high) line produces
// no spurious edge after reset.
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   line_i   in   raw asynchronous line
//   line_o   out  synchronized line level
//   rise_o   out  1-cycle pulse, synchronized line went 0 -> 1
//   fall_o   out  1-cycle pulse, synchronized line went 1 -> 0
module n64_line_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            prev_q <= sync_q[1];
        end
    end

    assign line_o = sync_q[1];
    assign rise_o = sync_q[1] & ~prev_q;
    assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/n64_receive_frame.sv
// n64_receive_frame
// Receive side of the N64/GC one-wire link. Measures each low pulse on the
// synchronized line, decodes data bits and the stop bit, assembles MSB-first
// bytes and reports frame completion or faults.
//   sys_clk_i      in   system clock (50 MHz)
//   rst_n_i        in   asynchronous active-low reset
//   enable_i       in   receiver armed; low forces IDLE
//   n64d_in_i      in   raw data line (asynchronous)
//   rx_byte_o      out  last completed byte, held
//   byte_valid_o   out  1-cycle pulse when rx_byte_o updates
//   frame_done_o   out  1-cycle pulse at end of a good frame
//   frame_bytes_o  out  byte count of last good frame (saturates at 63)
//   stop_type_o    out  1 = controller stop, 0 = console stop
//   frame_error_o  out  1-cycle pulse on a line or framing fault
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RX_IDLE  | no frame in progress, waiting for the first falling edge
// RX_LOW   | line low, measuring pulse width in cnt_q
// RX_HIGH  | line high after a valid pulse, counting toward end-of-frame
// RX_DRAIN | after a fault, waiting for the line to stay high long enough
module n64_receive_frame
    import n64_pkg::*;
#(
    parameter int unsigned GLITCH_MIN   = GLITCH_MIN_DEF,
    parameter int unsigned BIT_SPLIT    = BIT_SPLIT_DEF,
    parameter int unsigned STOP_SPLIT   = STOP_SPLIT_DEF,
    parameter int unsigned MAX_LOW      = MAX_LOW_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic       sys_clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       n64d_in_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_done_o,
    output logic [5:0] frame_bytes_o,
    output logic       stop_type_o,
    output logic       frame_error_o
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] GLITCH_C   = CNT_W'(GLITCH_MIN);
    localparam logic [CNT_W-1:0] BIT_C      = CNT_W'(BIT_SPLIT);
    localparam logic [CNT_W-1:0] STOP_C     = CNT_W'(STOP_SPLIT);
    localparam logic [CNT_W-1:0] MAX_LOW_C  = CNT_W'(MAX_LOW);
    localparam logic [CNT_W-1:0] IDLE_C     = CNT_W'(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_M1_C  = CNT_W'(IDLE_TIMEOUT - 1);

    logic line_s, rise_s, fall_s;

    n64_line_sync u_sync (
        .clk_i   (sys_clk_i),
        .rst_n_i (rst_n_i),
        .line_i  (n64d_in_i),
        .line_o  (line_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    rx_state_e        state_q, state_d;
    rx_state_e        resume_q, resume_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_save_q, cnt_save_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [5:0]       byte_cnt_q, byte_cnt_d;
    logic             pend_bit_q, pend_bit_d;
    logic             pend_stop_q, pend_stop_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [5:0]       frame_bytes_q, frame_bytes_d;
    logic             stop_type_q, stop_type_d;
    logic             frame_error_q, frame_error_d;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= RX_IDLE;
            resume_q      <= RX_IDLE;
            cnt_q         <= '0;
            cnt_save_q    <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            pend_bit_q    <= 1'b0;
            pend_stop_q   <= 1'b0;
            pend_valid_q  <= 1'b0;
            rx_byte_q     <= '0;
            byte_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_bytes_q <= '0;
            stop_type_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            cnt_q         <= cnt_d;
            cnt_save_q    <= cnt_save_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            pend_bit_q    <= pend_bit_d;
            pend_stop_q   <= pend_stop_d;
            pend_valid_q  <= pend_valid_d;
            rx_byte_q     <= rx_byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_done_q  <= frame_done_d;
            frame_bytes_q <= frame_bytes_d;
            stop_type_q   <= stop_type_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        cnt_d         = cnt_q;
        cnt_save_d    = cnt_save_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        pend_bit_d    = pend_bit_q;
        pend_stop_d   = pend_stop_q;
        pend_valid_d  = pend_valid_q;
        rx_byte_d     = rx_byte_q;
        byte_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        frame_bytes_d = frame_bytes_q;
        stop_type_d   = stop_type_q;
        frame_error_d = 1'b0;

        if (!enable_i) begin
            state_d      = RX_IDLE;
            cnt_d        = '0;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (fall_s) begin
                        state_d      = RX_LOW;
                        resume_d     = RX_IDLE;
                        cnt_d        = CNT_ONE;
                        cnt_save_d   = '0;
                        bit_cnt_d    = '0;
                        byte_cnt_d   = '0;
                        pend_valid_d = 1'b0;
                    end
                end

                RX_LOW: begin
                    if (cnt_q >= MAX_LOW_C) begin
                        frame_error_d = 1'b1;
                        state_d       = RX_DRAIN;
                        cnt_d         = '0;
                    end else if (rise_s) begin
                        if (cnt_q < GLITCH_C) begin
                            // Glitch: resume as if it never happened; the high
                            // time keeps accumulating across the glitch.
                            state_d = resume_q;
                            cnt_d   = cnt_save_q + cnt_q;
                        end else begin
                            pend_bit_d   = (cnt_q < BIT_C);
                            pend_stop_d  = (cnt_q >= STOP_C);
                            pend_valid_d = 1'b1;
                            state_d      = RX_HIGH;
                            cnt_d        = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                RX_HIGH: begin
                    if (fall_s) begin
                        // A further falling edge proves the pending bit was
                        // data, not stop. pend_valid guards against a second
                        // commit when a glitch returns us here.
                        if (pend_valid_q) begin
                            shift_d      = {shift_q[6:0], pend_bit_q};
                            bit_cnt_d    = bit_cnt_q + 3'd1;
                            pend_valid_d = 1'b0;
                            if (bit_cnt_q == 3'd7) begin
                                rx_byte_d    = {shift_q[6:0], pend_bit_q};
                                byte_valid_d = 1'b1;
                                byte_cnt_d   = byte_cnt_inc(byte_cnt_q);
                            end
                        end
                        state_d    = RX_LOW;
                        resume_d   = RX_HIGH;
                        cnt_save_d = cnt_q;
                        cnt_d      = CNT_ONE;
                    end else if (cnt_q >= IDLE_C) begin
                        if (bit_cnt_q == 3'd0 && byte_cnt_q != 6'd0) begin
                            frame_done_d  = 1'b1;
                            frame_bytes_d = byte_cnt_q;
                            stop_type_d   = pend_stop_q;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                        state_d      = RX_IDLE;
                        cnt_d        = '0;
                        pend_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                RX_DRAIN: begin
                    // Exit one count early so a falling edge arriving right
                    // after a full IDLE_TIMEOUT of high is seen from IDLE.
                    if (!line_s) begin
                        cnt_d = '0;
                    end else if (cnt_q >= IDLE_M1_C) begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rx_byte_o     = rx_byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_done_o  = frame_done_q;
    assign frame_bytes_o = frame_bytes_q;
    assign stop_type_o   = stop_type_q;
    assign frame_error_o = frame_error_q;

endmodule
